// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and widths for the PC fetch sequencer.
// Optional statistics counters are enabled with `define PC_SEQ_STATS_EN.
package pc_seq_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned STAT_W = 16;
    localparam int unsigned BUB_W  = 4;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} seq_state_t;

    typedef enum logic [1:0] {SEL_SEQ, SEL_BTB, SEL_FLUSH, SEL_HOLD} redirect_sel_t;

    // Saturating increment for the event counters
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bundle of redirect inputs and fetch outputs between the sequencer and its neighbours.
interface pc_fetch_sequencer_if;
    import pc_seq_pkg::*;

    logic                flush_pipeline;
    logic [PC_W-1:0]     true_address;
    logic                prediction;
    logic [PC_W-1:0]     BTB_address;
    logic                stall;
    logic [PC_W-1:0]     next_PC;
    logic                pc_valid;
    redirect_sel_t       redirect_sel;
    logic                halted;
    logic [STAT_W-1:0]   flush_count;
    logic [STAT_W-1:0]   predict_count;

    modport master (
        output flush_pipeline, true_address, prediction, BTB_address, stall,
        input  next_PC, pc_valid, redirect_sel, halted, flush_count, predict_count
    );

    modport slave (
        input  flush_pipeline, true_address, prediction, BTB_address, stall,
        output next_PC, pc_valid, redirect_sel, halted, flush_count, predict_count
    );

endinterface

// File: rtl/pc_fetch_sequencer_bubble_counter.sv
// Loadable down-counter timing the post-flush bubbles; done_o is set while the count is 1.
module bubble_counter
    import pc_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [BUB_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [BUB_W-1:0] count_q;
    logic             done_q;

    // Load wins over decrement so a re-flush restarts the bubble window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (load_i) begin
            count_q <= load_val_i;
            done_q  <= (load_val_i == BUB_W'(1));
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - BUB_W'(1);
            done_q  <= (count_q == BUB_W'(2));
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Next-PC sequencer: arbitrates flush / BTB / sequential sources, stalls, bubbles and halt.
// Define PC_SEQ_STATS_EN to build the saturating flush and prediction counters.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC      = 32'd0,
    parameter logic [PC_W-1:0] HALT_PC       = 32'd18,
    parameter int unsigned     FLUSH_BUBBLES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    pc_fetch_sequencer_if.slave bus
);

    seq_state_t    state_q, state_d;
    logic [PC_W-1:0] next_pc_q, next_pc_d;
    logic          valid_q, valid_d;
    redirect_sel_t sel_q, sel_d;
    logic          halted_q, halted_d;
    logic          cnt_load;
    logic          bub_done;
    logic          flush_acc;
    logic          pred_acc;

    bubble_counter u_bubble_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (BUB_W'(FLUSH_BUBBLES)),
        .dec_i      (state_q == FLUSH),
        .done_o     (bub_done)
    );

    always_comb begin
        state_d   = state_q;
        next_pc_d = next_pc_q;
        valid_d   = valid_q;
        sel_d     = sel_q;
        halted_d  = halted_q;
        cnt_load  = 1'b0;
        flush_acc = 1'b0;
        pred_acc  = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d   = RUN;
                valid_d   = 1'b1;
                next_pc_d = RESET_PC;
            end
            RUN: begin
                // Halt check outranks every redirect, flush included
                if (valid_q && (next_pc_q >= HALT_PC)) begin
                    state_d  = HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    sel_d    = SEL_HOLD;
                end else if (bus.flush_pipeline) begin
                    next_pc_d = bus.true_address;
                    sel_d     = SEL_FLUSH;
                    flush_acc = 1'b1;
                    if (FLUSH_BUBBLES != 0) begin
                        valid_d  = 1'b0;
                        cnt_load = 1'b1;
                        state_d  = FLUSH;
                    end else begin
                        valid_d  = 1'b1;
                    end
                end else if (bus.stall) begin
                    sel_d = SEL_HOLD;
                end else if (bus.prediction) begin
                    next_pc_d = bus.BTB_address;
                    sel_d     = SEL_BTB;
                    pred_acc  = 1'b1;
                end else begin
                    next_pc_d = next_pc_q + PC_W'(1);
                    sel_d     = SEL_SEQ;
                end
            end
            FLUSH: begin
                if (bus.flush_pipeline) begin
                    next_pc_d = bus.true_address;
                    sel_d     = SEL_FLUSH;
                    flush_acc = 1'b1;
                    cnt_load  = 1'b1;
                end else if (bub_done) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end
            end
            HALT: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            next_pc_q <= RESET_PC;
            valid_q   <= 1'b0;
            sel_q     <= SEL_HOLD;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            next_pc_q <= next_pc_d;
            valid_q   <= valid_d;
            sel_q     <= sel_d;
            halted_q  <= halted_d;
        end
    end

    assign bus.next_PC      = next_pc_q;
    assign bus.pc_valid     = valid_q;
    assign bus.redirect_sel = sel_q;
    assign bus.halted       = halted_q;

`ifdef PC_SEQ_STATS_EN
    logic [STAT_W-1:0] flush_cnt_q;
    logic [STAT_W-1:0] pred_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
            pred_cnt_q  <= '0;
        end else begin
            if (flush_acc) flush_cnt_q <= sat_inc(flush_cnt_q);
            if (pred_acc)  pred_cnt_q  <= sat_inc(pred_cnt_q);
        end
    end

    assign bus.flush_count   = flush_cnt_q;
    assign bus.predict_count = pred_cnt_q;
`else
    logic unused_stats;
    assign unused_stats      = flush_acc ^ pred_acc;
    assign bus.flush_count   = '0;
    assign bus.predict_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Table-driven bench for pc_fetch_sequencer with a scoreboard queue of expected outputs.
module tb_pc_fetch_sequencer;

`ifdef PC_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic [31:0] ta;
        logic        pred;
        logic [31:0] btb;
        logic        stall;
        logic [31:0] e_pc;
        logic        e_v;
        logic [1:0]  e_sel;
        logic        e_h;
        logic [15:0] e_fc;
        logic [15:0] e_pcn;
    } vec_t;

    logic clk;
    logic rst_n;
    pc_fetch_sequencer_if bus();

    pc_fetch_sequencer #(
        .RESET_PC      (32'd0),
        .HALT_PC       (32'd18),
        .FLUSH_BUBBLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec;
    int   n_miss;

    function automatic vec_t mk(input logic r, input logic f, input logic [31:0] ta,
                                input logic p, input logic [31:0] b, input logic s,
                                input logic [31:0] pc, input logic v, input logic [1:0] sel,
                                input logic h, input int fc, input int pcn);
        vec_t x;
        x.rst = r; x.flush = f; x.ta = ta; x.pred = p; x.btb = b; x.stall = s;
        x.e_pc = pc; x.e_v = v; x.e_sel = sel; x.e_h = h;
        x.e_fc = 16'(fc); x.e_pcn = 16'(pcn);
        return x;
    endfunction

    function automatic vec_t idle(input logic [31:0] pc, input logic v, input logic [1:0] sel,
                                  input int fc, input int pcn);
        return mk(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, pc, v, sel, 1'b0, fc, pcn);
    endfunction

    function automatic vec_t rst_vec();
        return mk(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 2'd3, 1'b0, 0, 0);
    endfunction

    task automatic compare(input int idx);
        vec_t e;
        logic [15:0] efc;
        logic [15:0] epn;
        logic [1:0]  sel;
        e   = sb.pop_front();
        efc = STATS ? e.e_fc  : 16'd0;
        epn = STATS ? e.e_pcn : 16'd0;
        sel = bus.redirect_sel;
        n_vec++;
        if (bus.next_PC !== e.e_pc || bus.pc_valid !== e.e_v || sel !== e.e_sel ||
            bus.halted !== e.e_h || bus.flush_count !== efc || bus.predict_count !== epn) begin
            n_miss++;
            $display("FAIL vec%0d: next_PC=%0h/%0h pc_valid=%b/%b redirect_sel=%0d/%0d halted=%b/%b flush_count=%0d/%0d predict_count=%0d/%0d (got/exp)",
                     idx, bus.next_PC, e.e_pc, bus.pc_valid, e.e_v, sel, e.e_sel,
                     bus.halted, e.e_h, bus.flush_count, efc, bus.predict_count, epn);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        bus.flush_pipeline = 1'b0;
        bus.true_address   = '0;
        bus.prediction     = 1'b0;
        bus.BTB_address    = '0;
        bus.stall          = 1'b0;

        // Free run from reset up to the halt address, then inputs ignored
        tbl.push_back(rst_vec());
        for (int i = 0; i <= 18; i++) tbl.push_back(idle(32'(i), 1'b1, (i == 0) ? 2'd3 : 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 32'd3, 0, 32'd0, 0, 32'd18, 0, 2'd3, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'd3, 1, 32'd4, 0, 32'd18, 0, 2'd3, 1, 0, 0));

        // BTB redirect, flush with bubbles, stall, re-flush during bubbles
        tbl.push_back(rst_vec());
        for (int i = 0; i <= 3; i++) tbl.push_back(idle(32'(i), 1'b1, (i == 0) ? 2'd3 : 2'd0, 0, 0));
        tbl.push_back(mk(0, 0, 32'd0, 1, 32'd10, 0, 32'd10, 1, 2'd1, 0, 0, 1));
        tbl.push_back(idle(32'd11, 1'b1, 2'd0, 0, 1));
        tbl.push_back(idle(32'd12, 1'b1, 2'd0, 0, 1));
        tbl.push_back(mk(0, 1, 32'd5, 0, 32'd0, 0, 32'd5, 0, 2'd2, 0, 1, 1));
        tbl.push_back(idle(32'd5, 1'b0, 2'd2, 1, 1));
        tbl.push_back(idle(32'd5, 1'b1, 2'd2, 1, 1));
        tbl.push_back(idle(32'd6, 1'b1, 2'd0, 1, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 32'd0, 0, 32'd0, 1, 32'd6, 1, 2'd3, 0, 1, 1));
        tbl.push_back(idle(32'd7, 1'b1, 2'd0, 1, 1));
        tbl.push_back(mk(0, 1, 32'd13, 0, 32'd0, 0, 32'd13, 0, 2'd2, 0, 2, 1));
        tbl.push_back(mk(0, 1, 32'd7,  0, 32'd0, 0, 32'd7,  0, 2'd2, 0, 3, 1));
        tbl.push_back(mk(0, 0, 32'd0,  1, 32'd2, 1, 32'd7,  0, 2'd2, 0, 3, 1));
        tbl.push_back(idle(32'd7, 1'b1, 2'd2, 3, 1));
        tbl.push_back(idle(32'd8, 1'b1, 2'd0, 3, 1));

        // Flush, prediction and stall together; then run to halt from the flushed PC
        tbl.push_back(rst_vec());
        for (int i = 0; i <= 4; i++) tbl.push_back(idle(32'(i), 1'b1, (i == 0) ? 2'd3 : 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 32'd9, 1, 32'd2, 1, 32'd9, 0, 2'd2, 0, 1, 0));
        tbl.push_back(idle(32'd9, 1'b0, 2'd2, 1, 0));
        tbl.push_back(idle(32'd9, 1'b1, 2'd2, 1, 0));
        for (int i = 10; i <= 18; i++) tbl.push_back(idle(32'(i), 1'b1, 2'd0, 1, 0));
        tbl.push_back(mk(0, 0, 32'd0, 0, 32'd0, 0, 32'd18, 0, 2'd3, 1, 1, 0));

        // Asynchronous reset in the middle of the bubble window
        tbl.push_back(rst_vec());
        tbl.push_back(idle(32'd0, 1'b1, 2'd3, 0, 0));
        tbl.push_back(idle(32'd1, 1'b1, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 32'd20, 0, 32'd0, 0, 32'd20, 0, 2'd2, 0, 1, 0));
        tbl.push_back(rst_vec());
        tbl.push_back(idle(32'd0, 1'b1, 2'd3, 0, 0));
        tbl.push_back(idle(32'd1, 1'b1, 2'd0, 0, 0));

        #3;
        for (int k = 0; k < tbl.size(); k++) begin
            vec_t v;
            v = tbl[k];
            bus.flush_pipeline = v.flush;
            bus.true_address   = v.ta;
            bus.prediction     = v.pred;
            bus.BTB_address    = v.btb;
            bus.stall          = v.stall;
            sb.push_back(v);
            if (v.rst) begin
                // Assert between edges: outputs must drop before any clock
                #2 rst_n = 1'b0;
                #1 compare(k);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end else begin
                @(posedge clk);
                #1 compare(k);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
